// File: rtl/ldst_pkg.sv
// rtl/ldst_pkg.sv - shared types and stack defaults for the load/store sequencer
package ldst_pkg;

   typedef enum logic [2:0] {
      OP_LOAD  = 3'd0,
      OP_STORE = 3'd1,
      OP_PUSH  = 3'd2,
      OP_POP   = 3'd3,
      OP_SETSP = 3'd4
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   localparam logic [7:0] STACK_TOP_DEF   = 8'hFF;
   localparam logic [7:0] STACK_LIMIT_DEF = 8'hE0;

   // Ops that touch dat_mem; anything else skips the address/data update.
   function automatic logic op_uses_mem(input op_t op);
      return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_PUSH) || (op == OP_POP);
   endfunction

endpackage

// File: rtl/ldst_sp.sv
// rtl/ldst_sp.sv - hardware stack pointer with full/empty flags
module ldst_sp
   import ldst_pkg::*;
#(
   parameter logic [7:0] STACK_TOP   = STACK_TOP_DEF,
   parameter logic [7:0] STACK_LIMIT = STACK_LIMIT_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       inc,
   input  logic       dec,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic [7:0] sp,
   output logic       full,
   output logic       empty
);

   logic [7:0] sp_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp_q <= STACK_TOP;
      end else if (load) begin
         sp_q <= load_val;
      end else if (inc) begin
         sp_q <= sp_q + 8'd1;
      end else if (dec) begin
         sp_q <= sp_q - 8'd1;
      end
   end

   // Equality only: SETSP may park sp outside [LIMIT,TOP] on purpose.
   assign sp    = sp_q;
   assign full  = (sp_q == STACK_LIMIT);
   assign empty = (sp_q == STACK_TOP);

endmodule

// File: rtl/ldst_unit.sv
// rtl/ldst_unit.sv - single-outstanding load/store/stack sequencer in front of dat_mem
module ldst_unit
   import ldst_pkg::*;
#(
   parameter logic [7:0] STACK_TOP   = STACK_TOP_DEF,
   parameter logic [7:0] STACK_LIMIT = STACK_LIMIT_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  op_t         req_op,
   input  logic [7:0]  req_addr,
   input  logic [7:0]  req_data,
   input  logic [11:0] req_pc,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [7:0]  rsp_data,
   output logic        rsp_err,
   output logic [7:0]  sp,
   output logic [7:0]  mem_addr,
   output logic [7:0]  mem_dat_in,
   output logic        mem_wr_en,
   output logic [11:0] mem_prog_ctr,
   input  logic [7:0]  mem_dat_out
);

   state_t     state, state_nxt;
   op_t        op_q;
   logic [7:0] addr_q;
   logic       accept;
   logic       in_access;
   logic       sp_full, sp_empty;
   logic       sp_inc, sp_dec, sp_load;

   assign accept    = req_valid && req_ready;
   assign in_access = (state == S_ACCESS);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (accept) state_nxt = S_ACCESS;
         S_ACCESS: state_nxt = S_RESP;
         S_RESP:   if (rsp_ready) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Write strobe comes straight off the state register so reset kills it at once.
   always_comb begin
      req_ready = (state == S_IDLE);
      rsp_valid = (state == S_RESP);
      mem_wr_en = 1'b0;
      if (in_access) begin
         case (op_q)
            OP_STORE: mem_wr_en = 1'b1;
            OP_PUSH:  mem_wr_en = !sp_full;
            default:  mem_wr_en = 1'b0;
         endcase
      end
   end

   // Memory-side registers are loaded at accept, so they are stable for all of ACCESS
   // and simply hold afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q         <= OP_LOAD;
         addr_q       <= 8'h00;
         mem_addr     <= 8'h00;
         mem_dat_in   <= 8'h00;
         mem_prog_ctr <= 12'h000;
      end else if (accept) begin
         op_q         <= req_op;
         addr_q       <= req_addr;
         mem_prog_ctr <= req_pc;
         if (op_uses_mem(req_op)) begin
            case (req_op)
               OP_PUSH: mem_addr <= sp;
               OP_POP:  mem_addr <= sp + 8'd1;
               default: mem_addr <= req_addr;
            endcase
         end
         if ((req_op == OP_STORE) || (req_op == OP_PUSH)) begin
            mem_dat_in <= req_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_data <= 8'h00;
         rsp_err  <= 1'b0;
      end else if (in_access) begin
         case (op_q)
            OP_LOAD: begin
               rsp_data <= mem_dat_out;
               rsp_err  <= 1'b0;
            end
            OP_STORE: begin
               rsp_data <= mem_dat_in;
               rsp_err  <= 1'b0;
            end
            OP_PUSH: begin
               rsp_data <= mem_dat_in;
               rsp_err  <= sp_full;
            end
            OP_POP: begin
               rsp_data <= sp_empty ? 8'h00 : mem_dat_out;
               rsp_err  <= sp_empty;
            end
            OP_SETSP: begin
               rsp_data <= addr_q;
               rsp_err  <= 1'b0;
            end
            default: begin
               rsp_data <= 8'h00;
               rsp_err  <= 1'b1;
            end
         endcase
      end
   end

   assign sp_dec  = in_access && (op_q == OP_PUSH) && !sp_full;
   assign sp_inc  = in_access && (op_q == OP_POP) && !sp_empty;
   assign sp_load = in_access && (op_q == OP_SETSP);

   ldst_sp #(
      .STACK_TOP   (STACK_TOP),
      .STACK_LIMIT (STACK_LIMIT)
   ) u_sp (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (sp_inc),
      .dec      (sp_dec),
      .load     (sp_load),
      .load_val (addr_q),
      .sp       (sp),
      .full     (sp_full),
      .empty    (sp_empty)
   );

endmodule

// File: tb/tb_ldst_unit.sv
// tb/tb_ldst_unit.sv - directed bench for ldst_unit with a behavioural dat_mem
module tb_ldst_unit;
   import ldst_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   op_t         req_op;
   logic [7:0]  req_addr;
   logic [7:0]  req_data;
   logic [11:0] req_pc;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [7:0]  rsp_data;
   logic        rsp_err;
   logic [7:0]  sp;
   logic [7:0]  mem_addr;
   logic [7:0]  mem_dat_in;
   logic        mem_wr_en;
   logic [11:0] mem_prog_ctr;
   logic [7:0]  mem_dat_out;

   logic [7:0]  mem [256];
   logic        mem_clr;
   int          wr_pulses;
   logic [7:0]  last_waddr;

   int errors;
   int checks;

   ldst_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_addr     (req_addr),
      .req_data     (req_data),
      .req_pc       (req_pc),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_data     (rsp_data),
      .rsp_err      (rsp_err),
      .sp           (sp),
      .mem_addr     (mem_addr),
      .mem_dat_in   (mem_dat_in),
      .mem_wr_en    (mem_wr_en),
      .mem_prog_ctr (mem_prog_ctr),
      .mem_dat_out  (mem_dat_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural dat_mem: synchronous write, combinational read.
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      end else if (mem_wr_en) begin
         mem[mem_addr] <= mem_dat_in;
         wr_pulses     <= wr_pulses + 1;
         last_waddr    <= mem_addr;
      end
   end
   assign mem_dat_out = mem[mem_addr];

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_req(input op_t op, input logic [7:0] a, input logic [7:0] d,
                         output logic [7:0] rd, output logic er,
                         output int wr_delta, output logic [7:0] waddr);
      int w0;
      int n;
      w0 = wr_pulses;
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = a;
      req_data  = d;
      req_pc    = req_pc + 12'd1;
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("rsp_latency", n[15:0], 16'd1);
      rd = rsp_data;
      er = rsp_err;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      wr_delta = wr_pulses - w0;
      waddr    = last_waddr;
   endtask

   logic [7:0] rd;
   logic       er;
   int         wd;
   logic [7:0] wa;
   int         w_base;

   initial begin
      errors    = 0;
      checks    = 0;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_op    = OP_LOAD;
      req_addr  = 8'h00;
      req_data  = 8'h00;
      req_pc    = 12'h100;
      rsp_ready = 1'b0;
      mem_clr   = 1'b1;
      wr_pulses = 0;

      repeat (3) @(negedge clk);
      mem_clr = 1'b0;
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_wr_en", mem_wr_en, 1'b0);
      chk("rst_sp", sp, 8'hFF);
      chk("rst_mem_addr", mem_addr, 8'h00);
      chk("rst_rsp_data", rsp_data, 8'h00);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_req_ready", req_ready, 1'b1);

      // 1: store then load back
      do_req(OP_STORE, 8'h10, 8'hA5, rd, er, wd, wa);
      chk("store_wr_cnt", wd[15:0], 16'd1);
      chk("store_wr_addr", wa, 8'h10);
      chk("store_rsp_data", rd, 8'hA5);
      chk("store_err", er, 1'b0);
      do_req(OP_LOAD, 8'h10, 8'h00, rd, er, wd, wa);
      chk("load_data", rd, 8'hA5);
      chk("load_err", er, 1'b0);
      chk("load_wr_cnt", wd[15:0], 16'd0);

      // 2: push/pop ordering
      do_req(OP_PUSH, 8'h00, 8'h11, rd, er, wd, wa);
      chk("push1_addr", wa, 8'hFF);
      chk("push1_cnt", wd[15:0], 16'd1);
      do_req(OP_PUSH, 8'h00, 8'h22, rd, er, wd, wa);
      chk("push2_addr", wa, 8'hFE);
      chk("push2_err", er, 1'b0);
      chk("push2_sp", sp, 8'hFD);
      do_req(OP_POP, 8'h00, 8'h00, rd, er, wd, wa);
      chk("pop1_data", rd, 8'h22);
      chk("pop1_sp", sp, 8'hFE);
      do_req(OP_POP, 8'h00, 8'h00, rd, er, wd, wa);
      chk("pop2_data", rd, 8'h11);
      chk("pop2_err", er, 1'b0);
      chk("pop2_sp", sp, 8'hFF);

      // 3: underflow
      do_req(OP_POP, 8'h00, 8'h00, rd, er, wd, wa);
      chk("uflow_err", er, 1'b1);
      chk("uflow_data", rd, 8'h00);
      chk("uflow_sp", sp, 8'hFF);
      chk("uflow_wr_cnt", wd[15:0], 16'd0);

      // 4: overflow at the limit
      do_req(OP_SETSP, 8'hE0, 8'h00, rd, er, wd, wa);
      chk("setsp_data", rd, 8'hE0);
      chk("setsp_sp", sp, 8'hE0);
      chk("setsp_wr_cnt", wd[15:0], 16'd0);
      do_req(OP_PUSH, 8'h00, 8'h77, rd, er, wd, wa);
      chk("oflow_err", er, 1'b1);
      chk("oflow_wr_cnt", wd[15:0], 16'd0);
      chk("oflow_sp", sp, 8'hE0);
      do_req(OP_SETSP, 8'hFF, 8'h00, rd, er, wd, wa);
      chk("restore_sp", sp, 8'hFF);

      // undefined opcode
      do_req(op_t'(3'd6), 8'h10, 8'h5A, rd, er, wd, wa);
      chk("undef_err", er, 1'b1);
      chk("undef_data", rd, 8'h00);
      chk("undef_wr_cnt", wd[15:0], 16'd0);

      // 5: response back-pressure with a competing request offered
      w_base = wr_pulses;
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = OP_LOAD;
      req_addr  = 8'h10;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = OP_STORE;
      req_addr  = 8'h30;
      req_data  = 8'h55;
      for (int i = 0; i < 5; i++) begin
         chk("hold_rsp_valid", rsp_valid, 1'b1);
         chk("hold_rsp_data", rsp_data, 8'hA5);
         chk("hold_req_ready", req_ready, 1'b0);
         @(negedge clk);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("hold_release_valid", rsp_valid, 1'b0);
      chk("hold_release_ready", req_ready, 1'b1);
      chk("hold_no_write", (wr_pulses - w_base), 16'd0);
      chk("hold_mem30", mem[8'h30], 8'h00);

      // 6: reset during the ACCESS cycle of a store
      do_req(OP_PUSH, 8'h00, 8'h33, rd, er, wd, wa);
      chk("pre_rst_sp", sp, 8'hFE);
      w_base = wr_pulses;
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = OP_STORE;
      req_addr  = 8'h20;
      req_data  = 8'h99;
      @(negedge clk);
      req_valid = 1'b0;
      chk("abort_wr_en_before", mem_wr_en, 1'b1);
      chk("abort_addr", mem_addr, 8'h20);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_wr_en_after", mem_wr_en, 1'b0);
      chk("abort_sp", sp, 8'hFF);
      chk("abort_rsp_valid", rsp_valid, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_mem20", mem[8'h20], 8'h00);
      chk("abort_wr_cnt", (wr_pulses - w_base), 16'd0);
      chk("abort_sp_after", sp, 8'hFF);
      chk("abort_req_ready", req_ready, 1'b1);
      chk("abort_rsp_after", rsp_valid, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
